// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches single-cycle events into fixed-length level pulses with a bounded queue
module pulse_stretch #(
  parameter int HIGH_CYCLES   = 10_000_000,
  parameter int GAP_CYCLES    = 5_000_000,
  parameter int PEND_MAX      = 3,
  parameter int PEND_W        = 2,
  parameter int CNT_W         = 24,
  parameter int IN_ACTIVE_LOW = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clr_overflow,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_LIM  = PEND_W'(PEND_MAX);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PEND_W-1:0] pend_nx;
  logic              ovf_nx;
  logic              consume;
  logic              ev;

  // Every sampled asserted cycle counts as an event; there is no edge detection.
  assign ev = (IN_ACTIVE_LOW != 0) ? ~pulse_in : pulse_in;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pending;
    ovf_nx   = overflow & ~clr_overflow;
    consume  = 1'b0;
    case (state)
      IDLE: begin
        if (ev) begin
          state_nx = HIGH;
          cnt_nx   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if ((pending != '0) || ev) begin
            state_nx = HIGH;
            cnt_nx   = HIGH_LOAD;
            consume  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // An event coinciding with a consume takes the consumed slot, so pending holds.
    if (state != IDLE) begin
      if (ev && !consume) begin
        if (pending < PEND_LIM) pend_nx = pending + PEND_W'(1);
        else                    ovf_nx  = 1'b1;
      end else if (consume && !ev) begin
        pend_nx = pending - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pending   <= pend_nx;
      overflow  <= ovf_nx;
      level_out <= (state_nx == HIGH);
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - directed self-checking bench for pulse_stretch
module tb_pulse_stretch;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       pulse_lo, pulse_hi;
  logic       clr_lo, clr_hi;
  logic       level_lo, busy_lo, ovf_lo;
  logic       level_hi, busy_hi, ovf_hi;
  logic [1:0] pend_lo, pend_hi;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(2), .PEND_W(2), .CNT_W(3),
                  .IN_ACTIVE_LOW(1)) u_lo (
    .clock(clock), .rst_n(rst_n), .pulse_in(pulse_lo), .clr_overflow(clr_lo),
    .level_out(level_lo), .busy(busy_lo), .pending(pend_lo), .overflow(ovf_lo));

  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(2), .PEND_W(2), .CNT_W(3),
                  .IN_ACTIVE_LOW(0)) u_hi (
    .clock(clock), .rst_n(rst_n), .pulse_in(pulse_hi), .clr_overflow(clr_hi),
    .level_out(level_hi), .busy(busy_hi), .pending(pend_hi), .overflow(ovf_hi));

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    pulse_lo = 1'b1;
    pulse_hi = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse_lo = 1'b1; pulse_hi = 1'b0; clr_lo = 1'b0; clr_hi = 1'b0;
    repeat (2) tick();
    checks++; if (level_lo !== 1'b0) begin errors++; $display("FAIL reset_level got %b exp 0", level_lo); end
    checks++; if (busy_lo !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_lo); end
    checks++; if (pend_lo !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pend_lo); end
    checks++; if (ovf_lo !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf_lo); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [0:9] evv = 10'b1000000000;
    logic [0:9] lv  = 10'b1111000000;
    logic [0:9] bz  = 10'b1111110000;
    for (int i = 0; i < 10; i++) begin
      pulse_lo = evv[i] ? 1'b0 : 1'b1;
      tick();
      checks++; if (level_lo !== lv[i]) begin errors++; $display("FAIL single_level E%0d got %b exp %b", i, level_lo, lv[i]); end
      checks++; if (busy_lo !== bz[i]) begin errors++; $display("FAIL single_busy E%0d got %b exp %b", i, busy_lo, bz[i]); end
      checks++; if (pend_lo !== 2'd0) begin errors++; $display("FAIL single_pending E%0d got %0d exp 0", i, pend_lo); end
    end
    settle();
  endtask

  task automatic test_queue();
    logic [0:19] evv = 20'b10101000000000000000;
    logic [0:19] lv  = 20'b11110011110011110000;
    logic [0:19] bz  = 20'b11111111111111111100;
    int pe [20] = '{0,0,1,1,2,2,1,1,1,1,1,1,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 20; i++) begin
      pulse_lo = evv[i] ? 1'b0 : 1'b1;
      tick();
      checks++; if (level_lo !== lv[i]) begin errors++; $display("FAIL queue_level E%0d got %b exp %b", i, level_lo, lv[i]); end
      checks++; if (busy_lo !== bz[i]) begin errors++; $display("FAIL queue_busy E%0d got %b exp %b", i, busy_lo, bz[i]); end
      checks++; if (pend_lo !== 2'(pe[i])) begin errors++; $display("FAIL queue_pending E%0d got %0d exp %0d", i, pend_lo, pe[i]); end
      checks++; if (ovf_lo !== 1'b0) begin errors++; $display("FAIL queue_overflow E%0d got %b exp 0", i, ovf_lo); end
    end
    settle();
  endtask

  task automatic test_overflow();
    logic [0:19] evv = 20'b11110000000000000000;
    logic [0:19] lv  = 20'b11110011110011110000;
    logic [0:19] ov  = 20'b00011111111111111111;
    int pe [20] = '{0,1,2,2,2,2,1,1,1,1,1,1,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 20; i++) begin
      pulse_lo = evv[i] ? 1'b0 : 1'b1;
      tick();
      checks++; if (level_lo !== lv[i]) begin errors++; $display("FAIL ovf_level E%0d got %b exp %b", i, level_lo, lv[i]); end
      checks++; if (pend_lo !== 2'(pe[i])) begin errors++; $display("FAIL ovf_pending E%0d got %0d exp %0d", i, pend_lo, pe[i]); end
      checks++; if (ovf_lo !== ov[i]) begin errors++; $display("FAIL ovf_flag E%0d got %b exp %b", i, ovf_lo, ov[i]); end
    end
    clr_lo = 1'b1;
    tick();
    clr_lo = 1'b0;
    checks++; if (ovf_lo !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf_lo); end
    tick();
    checks++; if (ovf_lo !== 1'b0) begin errors++; $display("FAIL ovf_clear_hold got %b exp 0", ovf_lo); end
    settle();
  endtask

  task automatic test_gap_end_event();
    logic [0:19] evv = 20'b11000010000000000000;
    logic [0:19] lv  = 20'b11110011110011110000;
    logic [0:19] bz  = 20'b11111111111111111100;
    int pe [20] = '{0,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 20; i++) begin
      pulse_lo = evv[i] ? 1'b0 : 1'b1;
      tick();
      checks++; if (level_lo !== lv[i]) begin errors++; $display("FAIL gapend_level E%0d got %b exp %b", i, level_lo, lv[i]); end
      checks++; if (busy_lo !== bz[i]) begin errors++; $display("FAIL gapend_busy E%0d got %b exp %b", i, busy_lo, bz[i]); end
      checks++; if (pend_lo !== 2'(pe[i])) begin errors++; $display("FAIL gapend_pending E%0d got %0d exp %0d", i, pend_lo, pe[i]); end
      checks++; if (ovf_lo !== 1'b0) begin errors++; $display("FAIL gapend_overflow E%0d got %b exp 0", i, ovf_lo); end
    end
    settle();
  endtask

  task automatic test_async_reset();
    logic [0:9] lv = 10'b1111000000;
    logic [0:9] bz = 10'b1111110000;
    for (int i = 0; i < 4; i++) begin
      pulse_lo = 1'b0;
      tick();
    end
    pulse_lo = 1'b1;
    checks++; if (pend_lo !== 2'd2) begin errors++; $display("FAIL areset_pre_pending got %0d exp 2", pend_lo); end
    checks++; if (ovf_lo !== 1'b1) begin errors++; $display("FAIL areset_pre_overflow got %b exp 1", ovf_lo); end
    checks++; if (level_lo !== 1'b1) begin errors++; $display("FAIL areset_pre_level got %b exp 1", level_lo); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (level_lo !== 1'b0) begin errors++; $display("FAIL areset_level got %b exp 0", level_lo); end
    checks++; if (busy_lo !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy_lo); end
    checks++; if (pend_lo !== 2'd0) begin errors++; $display("FAIL areset_pending got %0d exp 0", pend_lo); end
    checks++; if (ovf_lo !== 1'b0) begin errors++; $display("FAIL areset_overflow got %b exp 0", ovf_lo); end
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      pulse_lo = (i == 0) ? 1'b0 : 1'b1;
      tick();
      checks++; if (level_lo !== lv[i]) begin errors++; $display("FAIL areset_after_level E%0d got %b exp %b", i, level_lo, lv[i]); end
      checks++; if (busy_lo !== bz[i]) begin errors++; $display("FAIL areset_after_busy E%0d got %b exp %b", i, busy_lo, bz[i]); end
    end
    settle();
  endtask

  task automatic test_active_high();
    logic [0:9] lv = 10'b1111000000;
    logic [0:9] bz = 10'b1111110000;
    pulse_hi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (level_hi !== 1'b0) begin errors++; $display("FAIL ahigh_idle_level got %b exp 0", level_hi); end
      checks++; if (busy_hi !== 1'b0) begin errors++; $display("FAIL ahigh_idle_busy got %b exp 0", busy_hi); end
    end
    for (int i = 0; i < 10; i++) begin
      pulse_hi = (i == 0) ? 1'b1 : 1'b0;
      tick();
      checks++; if (level_hi !== lv[i]) begin errors++; $display("FAIL ahigh_level E%0d got %b exp %b", i, level_hi, lv[i]); end
      checks++; if (busy_hi !== bz[i]) begin errors++; $display("FAIL ahigh_busy E%0d got %b exp %b", i, busy_hi, bz[i]); end
      checks++; if (pend_hi !== 2'd0) begin errors++; $display("FAIL ahigh_pending E%0d got %0d exp 0", i, pend_hi); end
      checks++; if (ovf_hi !== 1'b0) begin errors++; $display("FAIL ahigh_overflow E%0d got %b exp 0", i, ovf_hi); end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_gap_end_event();
    test_async_reset();
    test_active_high();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
